// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button debounce block.
package btn_pkg;

  // Debounce FSM states. PRESSED and RELEASE_CHK both count as "held".
  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } btn_state_t;

  // Defaults target a 100 MHz clock: 1 ms sample tick, 10 ms debounce,
  // 500 ms to first repeat, then 10 repeats per second.
  localparam int unsigned DEF_SAMPLE_DIV       = 100000;
  localparam int unsigned DEF_DEBOUNCE_SAMPLES = 10;
  localparam int unsigned DEF_REPEAT_DELAY     = 500;
  localparam int unsigned DEF_REPEAT_RATE      = 100;

  // True for the states in which the debounced level reads as pressed.
  function automatic logic is_level_state(input btn_state_t s);
    return (s == PRESSED) || (s == RELEASE_CHK);
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running strobe generator: one-cycle tick every SAMPLE_DIV clocks.
module sample_tick_gen
  import btn_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = DEF_SAMPLE_DIV
) (
  input  logic clk,
  input  logic reset_p,
  output logic tick
);

  localparam int unsigned CW = $clog2(SAMPLE_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Count 0..SAMPLE_DIV-1 and wrap; never stalls.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: synchronizer, tick-sampled debounce FSM and
// auto-repeat timer producing clean one-cycle press/release/repeat pulses.
module btn_debounce_pulse
  import btn_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV       = DEF_SAMPLE_DIV,
  parameter int unsigned DEBOUNCE_SAMPLES = DEF_DEBOUNCE_SAMPLES,
  parameter int unsigned REPEAT_DELAY     = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE      = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic reset_p,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_pulse,
  output logic btn_release,
  output logic btn_rpt
);

  localparam int unsigned DW   = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW   = $clog2(RMAX + 1);

  localparam logic [DW-1:0] D_LAST  = DW'(DEBOUNCE_SAMPLES);
  localparam logic [RW-1:0] R_DELAY = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_RATE  = RW'(REPEAT_RATE);
  localparam logic [RW-1:0] R_MAX   = RW'(RMAX);

  logic       w_tick;
  logic       w_btn_s;

  logic       r_sync1;
  logic       r_sync2;

  btn_state_t r_state;
  btn_state_t w_state_next;
  logic [DW-1:0] r_dcnt;
  logic [DW-1:0] w_dcnt_next;
  logic [DW-1:0] w_dcnt_inc;
  logic [RW-1:0] r_rcnt;
  logic [RW-1:0] w_rcnt_next;
  logic [RW-1:0] w_rcnt_inc;
  logic [RW-1:0] w_rpt_thresh;
  // Set after the first repeat so the cadence switches from DELAY to RATE.
  logic       r_rpt_armed;
  logic       w_rpt_armed_next;

  logic       r_level;
  logic       r_pulse;
  logic       r_release;
  logic       r_rpt;
  logic       w_pulse_next;
  logic       w_release_next;
  logic       w_rpt_next;

  sample_tick_gen #(
    .SAMPLE_DIV (SAMPLE_DIV)
  ) u_tick (
    .clk     (clk),
    .reset_p (reset_p),
    .tick    (w_tick)
  );

  // Two-flop synchronizer; btn_in is asynchronous to clk.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_btn_s = r_sync2;

  // Saturating increments so counters can never wrap.
  assign w_dcnt_inc   = (r_dcnt == D_LAST) ? r_dcnt : (r_dcnt + DW'(1));
  assign w_rcnt_inc   = (r_rcnt == R_MAX)  ? r_rcnt : (r_rcnt + RW'(1));
  assign w_rpt_thresh = r_rpt_armed ? R_RATE : R_DELAY;

  // Next-state and pulse decisions; nothing moves except on a sample tick.
  always_comb begin
    w_state_next     = r_state;
    w_dcnt_next      = r_dcnt;
    w_rcnt_next      = r_rcnt;
    w_rpt_armed_next = r_rpt_armed;
    w_pulse_next     = 1'b0;
    w_release_next   = 1'b0;
    w_rpt_next       = 1'b0;
    if (w_tick) begin
      case (r_state)
        RELEASED: begin
          if (w_btn_s) begin
            w_state_next = PRESS_CHK;
            w_dcnt_next  = DW'(1);
          end
        end
        PRESS_CHK: begin
          if (w_btn_s) begin
            if (w_dcnt_inc == D_LAST) begin
              w_state_next     = PRESSED;
              w_pulse_next     = 1'b1;
              w_dcnt_next      = '0;
              w_rcnt_next      = '0;
              w_rpt_armed_next = 1'b0;
            end else begin
              w_dcnt_next = w_dcnt_inc;
            end
          end else begin
            // Glitch rejected: back to idle silently.
            w_state_next = RELEASED;
            w_dcnt_next  = '0;
          end
        end
        PRESSED: begin
          if (w_btn_s) begin
            if (w_rcnt_inc == w_rpt_thresh) begin
              w_rpt_next       = 1'b1;
              w_rcnt_next      = '0;
              w_rpt_armed_next = 1'b1;
            end else begin
              w_rcnt_next = w_rcnt_inc;
            end
          end else begin
            w_state_next = RELEASE_CHK;
            w_dcnt_next  = DW'(1);
          end
        end
        RELEASE_CHK: begin
          if (!w_btn_s) begin
            if (w_dcnt_inc == D_LAST) begin
              w_state_next   = RELEASED;
              w_release_next = 1'b1;
              w_dcnt_next    = '0;
            end else begin
              w_dcnt_next = w_dcnt_inc;
            end
          end else begin
            // Bounce while held: resume repeats where they left off.
            w_state_next = PRESSED;
            w_dcnt_next  = '0;
          end
        end
        default: begin
          w_state_next = RELEASED;
          w_dcnt_next  = '0;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_state     <= RELEASED;
      r_dcnt      <= '0;
      r_rcnt      <= '0;
      r_rpt_armed <= 1'b0;
      r_level     <= 1'b0;
      r_pulse     <= 1'b0;
      r_release   <= 1'b0;
      r_rpt       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_dcnt      <= w_dcnt_next;
      r_rcnt      <= w_rcnt_next;
      r_rpt_armed <= w_rpt_armed_next;
      r_level     <= is_level_state(w_state_next);
      r_pulse     <= w_pulse_next;
      r_release   <= w_release_next;
      r_rpt       <= w_rpt_next;
    end
  end

  assign btn_level   = r_level;
  assign btn_pulse   = r_pulse;
  assign btn_release = r_release;
  assign btn_rpt     = r_rpt;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Self-checking bench for btn_debounce_pulse against a per-sample
// behavioural model of the debounce and repeat rules.
module tb_btn_debounce_pulse;

  localparam int DIV  = 4;
  localparam int DB   = 3;
  localparam int DLY  = 8;
  localparam int RATE = 4;

  logic clk = 1'b0;
  logic reset_p = 1'b1;
  logic btn_in = 1'b0;
  logic btn_level, btn_pulse, btn_release, btn_rpt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: edge count since reset, synchronizer image, accepted level,
  // run of samples disagreeing with the level, ticks held, next repeat point.
  int m_n, m_run, m_held, m_next_rpt;
  bit m_s1, m_s2, m_level;
  bit e_level, e_pulse, e_rel, e_rpt;

  int d_p = 0, d_r = 0, d_rp = 0;

  always #5 clk = ~clk;

  btn_debounce_pulse #(
    .SAMPLE_DIV       (DIV),
    .DEBOUNCE_SAMPLES (DB),
    .REPEAT_DELAY     (DLY),
    .REPEAT_RATE      (RATE)
  ) dut (
    .clk         (clk),
    .reset_p     (reset_p),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .btn_pulse   (btn_pulse),
    .btn_release (btn_release),
    .btn_rpt     (btn_rpt)
  );

  task automatic check_eq(input string tag, input int obs, input int want);
    checks++;
    if (obs != want) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, want, cyc);
    end
  endtask

  task automatic model_update();
    if (reset_p) begin
      m_n = 0; m_s1 = 0; m_s2 = 0; m_level = 0;
      m_run = 0; m_held = 0; m_next_rpt = DLY;
      e_pulse = 0; e_rel = 0; e_rpt = 0;
    end else begin
      e_pulse = 0; e_rel = 0; e_rpt = 0;
      if (m_n % DIV == DIV - 1) begin
        if (!m_level) begin
          if (m_s2) begin
            m_run++;
            if (m_run == DB) begin
              m_level = 1; e_pulse = 1; m_run = 0;
              m_held = 0; m_next_rpt = DLY;
            end
          end else begin
            m_run = 0;
          end
        end else begin
          if (m_s2) begin
            if (m_run > 0) begin
              m_run = 0;
            end else begin
              m_held++;
              if (m_held == m_next_rpt) begin
                e_rpt = 1;
                m_next_rpt += RATE;
              end
            end
          end else begin
            m_run++;
            if (m_run == DB) begin
              m_level = 0; e_rel = 1; m_run = 0;
            end
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = btn_in;
      m_n++;
    end
    e_level = m_level;
  endtask

  // One clock: model on the rising edge, compare on the falling edge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    cyc++;
    check_eq("level", btn_level, e_level);
    check_eq("pulse", btn_pulse, e_pulse);
    check_eq("release", btn_release, e_rel);
    check_eq("rpt", btn_rpt, e_rpt);
    check_eq("exclusive", ((int'(btn_pulse) + int'(btn_release) + int'(btn_rpt)) > 1) ? 1 : 0, 0);
    if (btn_pulse)   begin d_p++;  $display("cycle %0d: press pulse", cyc); end
    if (btn_release) begin d_r++;  $display("cycle %0d: release pulse", cyc); end
    if (btn_rpt)     begin d_rp++; $display("cycle %0d: repeat pulse", cyc); end
  endtask

  task automatic hold(input bit v, input int ticks);
    btn_in = v;
    repeat (ticks * DIV) step();
  endtask

  task automatic async_reset_check(input string tag);
    reset_p = 1'b1;
    #1;
    check_eq({tag, "_level"}, btn_level, 0);
    check_eq({tag, "_pulse"}, btn_pulse, 0);
    check_eq({tag, "_release"}, btn_release, 0);
    check_eq({tag, "_rpt"}, btn_rpt, 0);
    repeat (3) step();
    reset_p = 1'b0;
  endtask

  initial begin
    int p0, r0, rp0;
    int i;

    // Reset state
    repeat (3) step();
    check_eq("reset_level", btn_level, 0);
    reset_p = 1'b0;
    repeat (2) step();

    // 1: clean press held 20 ticks, then release
    p0 = d_p; r0 = d_r;
    hold(1, 20);
    check_eq("s1_level_held", btn_level, 1);
    hold(0, 6);
    check_eq("s1_pulses", d_p - p0, 1);
    check_eq("s1_releases", d_r - r0, 1);

    // 2: bouncy press 1,0,1,1,0 then steady 1
    p0 = d_p; rp0 = d_rp;
    hold(1, 1); hold(0, 1); hold(1, 2); hold(0, 1);
    check_eq("s2_no_pulse_bounce", d_p - p0, 0);
    hold(1, 5);
    check_eq("s2_pulses", d_p - p0, 1);
    check_eq("s2_no_rpt", d_rp - rp0, 0);
    hold(0, 6);

    // 3: held 26 ticks: pulse at sample 3, 23 held samples -> repeats at 8,12,16,20
    p0 = d_p; rp0 = d_rp;
    hold(1, 26);
    check_eq("s3_pulses", d_p - p0, 1);
    check_eq("s3_rpts", d_rp - rp0, 4);
    hold(0, 6);

    // 4: single 0 glitch while held; 9 held samples, glitch, return, 9 more
    p0 = d_p; r0 = d_r; rp0 = d_rp;
    hold(1, DB + 9);
    hold(0, 1);
    check_eq("s4_level_in_chk", btn_level, 1);
    hold(1, 10);
    check_eq("s4_no_release", d_r - r0, 0);
    check_eq("s4_rpts", d_rp - rp0, 3);
    hold(0, 6);

    // 5: reset mid-PRESS_CHK, then mid-PRESSED, button held throughout
    btn_in = 1'b1;
    for (i = 0; i < 100 && !(m_level == 0 && m_run == 2); i++) step();
    check_eq("s5_reached_press_chk", (i < 100) ? 1 : 0, 1);
    async_reset_check("s5_rst_chk");
    p0 = d_p;
    repeat ((DB + 2) * DIV + 4) step();
    check_eq("s5_pulse_after_rst1", d_p - p0, 1);
    for (i = 0; i < 100 && !(m_level == 1 && m_held >= 2); i++) step();
    check_eq("s5_reached_pressed", (i < 100) ? 1 : 0, 1);
    async_reset_check("s5_rst_pressed");
    p0 = d_p;
    repeat ((DB + 2) * DIV + 4) step();
    check_eq("s5_pulse_after_rst2", d_p - p0, 1);
    hold(0, 6);

    // 6: 2-clk pulse placed so no sample point sees it
    p0 = d_p; r0 = d_r; rp0 = d_rp;
    for (i = 0; i < 20 && (m_n % DIV != 2); i++) step();
    check_eq("s6_phase_found", (i < 20) ? 1 : 0, 1);
    btn_in = 1'b1;
    step(); step();
    btn_in = 1'b0;
    repeat (4 * DIV) step();
    check_eq("s6_no_pulse", d_p - p0, 0);
    check_eq("s6_no_release", d_r - r0, 0);
    check_eq("s6_no_rpt", d_rp - rp0, 0);
    check_eq("s6_level", btn_level, 0);

    // Random segments: mix of sub-tick glitches and multi-tick holds
    for (int s = 0; s < 40; s++) begin
      bit v;
      v = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        btn_in = v;
        repeat ($urandom_range(1, 3)) step();
      end else begin
        hold(v, $urandom_range(1, 14));
      end
    end
    hold(0, 6);
    check_eq("final_level", btn_level, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
